// File: rtl/jam_cost_table_if.sv
// Load-stream and lookup bundle between the matrix source / JAM engine and jam_cost_table.
// master drives the stream and lookup indices; slave is the cost table itself.
interface jam_cost_table_if #(
  parameter int COST_W = 7
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [COST_W-1:0] in_data;
  logic              in_last;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              table_ready;
  logic              err;

  modport master (
    output start, in_valid, in_data, in_last, W, J,
    input  in_ready, Cost, table_ready, err
  );

  modport slave (
    input  start, in_valid, in_data, in_last, W, J,
    output in_ready, Cost, table_ready, err
  );
endinterface

// File: rtl/jam_cost_table.sv
// 8x8 worker/job cost store for the JAM search engine: loads a row-major 64-beat
// stream, checks its framing, and serves combinational (W,J) lookups once complete.
module jam_cost_table #(
  parameter int N_IDX  = 8,
  parameter int COST_W = 7
) (
  input  logic            CLK,
  input  logic            RST,
  jam_cost_table_if.slave bus
);
  localparam int              DEPTH    = N_IDX * N_IDX;
  localparam logic [5:0]      LAST_IDX = 6'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              wr_en;
  logic [COST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // start has priority everywhere: it restarts the load and drops any same-cycle beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (bus.start) begin
      state_d = S_LOAD;
      cnt_d   = '0;
    end else if (state_q == S_LOAD && bus.in_valid) begin
      wr_en = 1'b1;
      cnt_d = cnt_q + 6'd1;
      if (bus.in_last)
        state_d = (cnt_q == LAST_IDX) ? S_READY : S_ERR;
      else if (cnt_q == LAST_IDX)
        state_d = S_ERR;
    end
  end

  // Storage is deliberately unreset; it is masked off until the table is READY.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[cnt_q] <= bus.in_data;
  end

  assign bus.in_ready    = (state_q == S_LOAD);
  assign bus.table_ready = (state_q == S_READY);
  assign bus.err         = (state_q == S_ERR);
  assign bus.Cost        = bus.table_ready ? mem_q[{bus.W, bus.J}] : '0;
endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table: framing, bubbles, abort, async reset and reload.
module tb_jam_cost_table;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  jam_cost_table_if #(.COST_W(7)) bus ();

  jam_cost_table #(.N_IDX(8), .COST_W(7)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // sel 0: cost = W*8+J ; sel 1: cost = (3*idx+5) mod 128
  function automatic logic [6:0] pat(input int sel, input int i);
    if (sel == 0) return 7'(i % 128);
    return 7'((i * 3 + 5) % 128);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [6:0] d, input bit last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_rng(input int sel, input int from, input int to,
                          input int last_at, input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps && (i % 5 == 2)) repeat (i % 3 + 1) tick();
      beat(pat(sel, i), i == last_at);
    end
  endtask

  task automatic look(input int w, input int j);
    bus.W = 3'(w);
    bus.J = 3'(j);
    #1;
  endtask

  task automatic test_reset();
    look(5, 3);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.table_ready !== 1'b0) begin errors++; $display("FAIL reset_table_ready got=%b exp=0", bus.table_ready); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.Cost !== 7'd0) begin errors++; $display("FAIL reset_cost_53 got=%0d exp=0", bus.Cost); end
    look(7, 7);
    checks++; if (bus.Cost !== 7'd0) begin errors++; $display("FAIL reset_cost_77 got=%0d exp=0", bus.Cost); end
  endtask

  task automatic test_full_load();
    pulse_start();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready got=%b exp=1", bus.in_ready); end
    load_rng(0, 0, 63, 63, 1'b0);
    checks++; if (bus.table_ready !== 1'b0) begin errors++; $display("FAIL load_early_ready got=%b exp=0", bus.table_ready); end
    beat(pat(0, 63), 1'b1);
    checks++; if (bus.table_ready !== 1'b1) begin errors++; $display("FAIL load_table_ready got=%b exp=1", bus.table_ready); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready_done got=%b exp=0", bus.in_ready); end
    look(5, 3);
    checks++; if (bus.Cost !== 7'd43) begin errors++; $display("FAIL load_cost_53 got=%0d exp=43", bus.Cost); end
    look(7, 7);
    checks++; if (bus.Cost !== 7'd63) begin errors++; $display("FAIL load_cost_77 got=%0d exp=63", bus.Cost); end
    look(0, 0);
    checks++; if (bus.Cost !== 7'd0) begin errors++; $display("FAIL load_cost_00 got=%0d exp=0", bus.Cost); end
    // Input stream wiggling outside LOAD must not disturb the resident matrix.
    beat(7'd99, 1'b1);
    look(2, 6);
    checks++; if (bus.Cost !== 7'd22) begin errors++; $display("FAIL load_stable_26 got=%0d exp=22", bus.Cost); end
  endtask

  task automatic test_bubbles();
    pulse_start();
    checks++; if (bus.table_ready !== 1'b0) begin errors++; $display("FAIL bub_ready_drop got=%b exp=0", bus.table_ready); end
    load_rng(1, 0, 63, 63, 1'b1);
    repeat (3) tick();
    checks++; if (bus.table_ready !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bub_wait_state got=%b%b exp=01", bus.table_ready, bus.in_ready); end
    beat(pat(1, 63), 1'b1);
    checks++; if (bus.table_ready !== 1'b1) begin errors++; $display("FAIL bub_table_ready got=%b exp=1", bus.table_ready); end
    for (int k = 0; k < 64; k += 9) begin
      look(k / 8, k % 8);
      checks++; if (bus.Cost !== pat(1, k)) begin errors++; $display("FAIL bub_cost_%0d got=%0d exp=%0d", k, bus.Cost, pat(1, k)); end
    end
  endtask

  task automatic test_early_last();
    pulse_start();
    load_rng(0, 0, 11, 10, 1'b0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL early_err got=%b exp=1", bus.err); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL early_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.table_ready !== 1'b0) begin errors++; $display("FAIL early_table_ready got=%b exp=0", bus.table_ready); end
    pulse_start();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL early_err_clear got=%b exp=0", bus.err); end
    load_rng(0, 0, 64, 63, 1'b0);
    look(5, 3);
    checks++; if (bus.table_ready !== 1'b1 || bus.Cost !== 7'd43) begin errors++; $display("FAIL early_reload got=%b/%0d exp=1/43", bus.table_ready, bus.Cost); end
  endtask

  task automatic test_missing_last();
    pulse_start();
    load_rng(0, 0, 64, -1, 1'b0);
    look(5, 3);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL miss_err got=%b exp=1", bus.err); end
    checks++; if (bus.Cost !== 7'd0) begin errors++; $display("FAIL miss_cost got=%0d exp=0", bus.Cost); end
    checks++; if (bus.in_ready !== 1'b0 || bus.table_ready !== 1'b0) begin errors++; $display("FAIL miss_flags got=%b%b exp=00", bus.in_ready, bus.table_ready); end
  endtask

  task automatic test_abort();
    pulse_start();
    load_rng(0, 0, 30, -1, 1'b0);
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 7'd99; bus.in_last = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL abort_state got=%b%b exp=10", bus.in_ready, bus.err); end
    load_rng(1, 0, 64, 63, 1'b0);
    look(0, 0);
    checks++; if (bus.table_ready !== 1'b1 || bus.Cost !== 7'd5) begin errors++; $display("FAIL abort_reload got=%b/%0d exp=1/5", bus.table_ready, bus.Cost); end
    look(3, 6);
    checks++; if (bus.Cost !== pat(1, 30)) begin errors++; $display("FAIL abort_cost30 got=%0d exp=%0d", bus.Cost, pat(1, 30)); end
  endtask

  task automatic test_rst_midload();
    pulse_start();
    load_rng(0, 0, 20, -1, 1'b0);
    RST = 1'b1;
    look(1, 1);
    checks++; if (bus.in_ready !== 1'b0 || bus.table_ready !== 1'b0 || bus.err !== 1'b0 || bus.Cost !== 7'd0) begin errors++; $display("FAIL rst_async got=%b%b%b/%0d exp=000/0", bus.in_ready, bus.table_ready, bus.err, bus.Cost); end
    tick();
    RST = 1'b0;
    load_rng(0, 0, 5, 4, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.err !== 1'b0 || bus.table_ready !== 1'b0) begin errors++; $display("FAIL rst_no_resume got=%b%b%b exp=000", bus.in_ready, bus.err, bus.table_ready); end
    pulse_start();
    load_rng(0, 0, 64, 63, 1'b0);
    look(7, 7);
    checks++; if (bus.table_ready !== 1'b1 || bus.Cost !== 7'd63) begin errors++; $display("FAIL rst_reload got=%b/%0d exp=1/63", bus.table_ready, bus.Cost); end
  endtask

  task automatic test_reload();
    pulse_start();
    look(5, 3);
    checks++; if (bus.table_ready !== 1'b0 || bus.Cost !== 7'd0) begin errors++; $display("FAIL rel_drop got=%b/%0d exp=0/0", bus.table_ready, bus.Cost); end
    load_rng(1, 0, 40, -1, 1'b0);
    checks++; if (bus.Cost !== 7'd0) begin errors++; $display("FAIL rel_mid_cost got=%0d exp=0", bus.Cost); end
    load_rng(1, 40, 64, 63, 1'b0);
    look(5, 3);
    checks++; if (bus.Cost !== pat(1, 43)) begin errors++; $display("FAIL rel_cost_53 got=%0d exp=%0d", bus.Cost, pat(1, 43)); end
    look(7, 7);
    checks++; if (bus.Cost !== pat(1, 63)) begin errors++; $display("FAIL rel_cost_77 got=%0d exp=%0d", bus.Cost, pat(1, 63)); end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.W = '0; bus.J = '0;
    #12;
    test_reset();
    RST = 1'b0;
    tick();
    test_full_load();
    test_bubbles();
    test_early_last();
    test_missing_last();
    test_abort();
    test_rst_midload();
    test_full_load();
    test_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
